// File: rtl/toy_fetch_unit_if.sv
// toy_fetch_unit_if: bundles the instruction-memory read port and the
// opcode/operand issue port of the toy fetch unit.
//
// Handshakes:
//   imem:  the fetch unit raises imem_req with imem_addr and holds both until
//          imem_ack=1; imem_rdata is consumed on that same edge.
//   issue: the fetch unit raises instr_valid with opcode/operand held stable;
//          the instruction retires on the edge where instr_valid=1 and
//          instr_ready=1. carry/zero are meaningful only on that edge.
//
// Modports:
//   master - the fetch unit (drives req/addr, opcode/operand/valid)
//   slave  - memory + datapath side (drives ack/rdata, ready, flags)
interface toy_fetch_unit_if #(
  parameter int PC_W = 8
);
  logic              imem_req;
  logic [PC_W-1:0]   imem_addr;
  logic              imem_ack;
  logic [PC_W+3:0]   imem_rdata;
  logic [3:0]        opcode;
  logic [PC_W-1:0]   operand;
  logic              instr_valid;
  logic              instr_ready;
  logic              carry;
  logic              zero;

  modport master (
    output imem_req, imem_addr, opcode, operand, instr_valid,
    input  imem_ack, imem_rdata, instr_ready, carry, zero
  );

  modport slave (
    input  imem_req, imem_addr, opcode, operand, instr_valid,
    output imem_ack, imem_rdata, instr_ready, carry, zero
  );
endinterface

// File: rtl/toy_fetch_unit.sv
// toy_fetch_unit: instruction sequencer for the toy accumulator CPU.
// Fetches one instruction at a time from instruction memory, presents it to
// the decoder, and on retirement resolves the next PC (JMP/BCC/BNE or PC+1).
// Fetching opcode 4'b0111 halts the unit until reset.
//
// Ports:
//   clk, rst_n  - rising-edge clock, asynchronous active-low reset
//   start       - leave IDLE and begin fetching from pc (ignored elsewhere)
//   bus         - toy_fetch_unit_if.master (imem req/ack, issue valid/ready,
//                 carry/zero flags)
//   pc          - current program counter
//   illegal     - sticky, set when the illegal opcode is fetched
//   retired     - saturating count of retired instructions
//   state_dbg   - current FSM state (0 IDLE, 1 FETCH, 2 ISSUE, 3 HALT)
module toy_fetch_unit #(
  parameter int PC_W  = 8,
  parameter int RET_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  toy_fetch_unit_if.master bus,
  output logic [PC_W-1:0]  pc,
  output logic             illegal,
  output logic [RET_W-1:0] retired,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_ISSUE = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam logic [3:0] OP_JMP = 4'b0000;
  localparam logic [3:0] OP_ILL = 4'b0111;
  localparam logic [3:0] OP_BCC = 4'b1010;
  localparam logic [3:0] OP_BNE = 4'b1011;

  state_t           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [RET_W-1:0] ret_q, ret_d;
  logic [3:0]       opc_q, opc_d;
  logic [PC_W-1:0]  opr_q, opr_d;
  logic             req_q, req_d;
  logic             valid_q, valid_d;
  logic             ill_q, ill_d;

  logic [3:0]       fetched_opc;
  logic             take_branch;

  assign fetched_opc = bus.imem_rdata[PC_W+3:PC_W];

  // Flags are only looked at here, and this term is only used on the
  // retire edge, so flag activity during the wait has no effect.
  assign take_branch = (opc_q == OP_JMP) ||
                       ((opc_q == OP_BCC) && !bus.carry) ||
                       ((opc_q == OP_BNE) && !bus.zero);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ret_d   = ret_q;
    opc_d   = opc_q;
    opr_d   = opr_q;
    req_d   = req_q;
    valid_d = valid_q;
    ill_d   = ill_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          req_d   = 1'b1;
        end
      end

      S_FETCH: begin
        if (bus.imem_ack) begin
          opc_d = fetched_opc;
          opr_d = bus.imem_rdata[PC_W-1:0];
          req_d = 1'b0;
          if (fetched_opc == OP_ILL) begin
            state_d = S_HALT;
            ill_d   = 1'b1;
          end else begin
            state_d = S_ISSUE;
            valid_d = 1'b1;
          end
        end
      end

      S_ISSUE: begin
        if (bus.instr_ready) begin
          pc_d    = take_branch ? opr_q : pc_q + PC_W'(1);
          if (ret_q != '1) begin
            ret_d = ret_q + RET_W'(1);
          end
          valid_d = 1'b0;
          // Go straight back to fetching: req rises in the first FETCH cycle.
          req_d   = 1'b1;
          state_d = S_FETCH;
        end
      end

      S_HALT: begin
        req_d   = 1'b0;
        valid_d = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ret_q   <= '0;
      opc_q   <= '0;
      opr_q   <= '0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ret_q   <= ret_d;
      opc_q   <= opc_d;
      opr_q   <= opr_d;
      req_q   <= req_d;
      valid_q <= valid_d;
      ill_q   <= ill_d;
    end
  end

  // imem_addr comes straight from the pc register, so it is registered too.
  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = pc_q;
  assign bus.opcode      = opc_q;
  assign bus.operand     = opr_q;
  assign bus.instr_valid = valid_q;
  assign pc              = pc_q;
  assign illegal         = ill_q;
  assign retired         = ret_q;
  assign state_dbg       = state_q;

endmodule

// File: tb/tb_toy_fetch_unit.sv
module tb_toy_fetch_unit;
  localparam int PC_W  = 8;
  localparam int RET_W = 16;
  localparam int W     = PC_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  always #5 clk = ~clk;

  toy_fetch_unit_if #(.PC_W(PC_W)) bus ();
  logic [PC_W-1:0]  pc;
  logic             illegal;
  logic [RET_W-1:0] retired;
  logic [1:0]       state_dbg;

  toy_fetch_unit #(.PC_W(PC_W), .RET_W(RET_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .bus       (bus),
    .pc        (pc),
    .illegal   (illegal),
    .retired   (retired),
    .state_dbg (state_dbg)
  );

  // ---------------- reference model state ----------------
  logic [PC_W+3:0] mem [0:(1<<PC_W)-1];
  logic [W-1:0]    exp_q [$];
  logic [PC_W-1:0] m_pc;
  int              m_ret;
  int              total = 0;
  int              bad   = 0;

  // Next PC from the instruction rules, in plain arithmetic.
  function automatic logic [PC_W-1:0] model_next_pc(input logic [PC_W-1:0] cur,
                                                    input logic [PC_W+3:0] instr,
                                                    input logic c, input logic z);
    int op;
    int tgt;
    int nxt;
    op  = int'(instr[PC_W+3:PC_W]);
    tgt = int'(instr[PC_W-1:0]);
    nxt = (int'(cur) + 1) % (1 << PC_W);
    if (op == 0) return PC_W'(tgt);
    if (op == 10 && c == 1'b0) return PC_W'(tgt);
    if (op == 11 && z == 1'b0) return PC_W'(tgt);
    return PC_W'(nxt);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    bus.imem_ack = 1'b0;
    bus.imem_rdata = '0;
    bus.instr_ready = 1'b0;
    bus.carry = 1'b0;
    bus.zero = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_retired", 32'(retired), 32'h0);
    chk("rst_illegal", 32'(illegal), 32'h0);
    chk("rst_req", 32'(bus.imem_req), 32'h0);
    chk("rst_valid", 32'(bus.instr_valid), 32'h0);
    chk("rst_opcode", 32'(bus.opcode), 32'h0);
    chk("rst_operand", 32'(bus.operand), 32'h0);
    rst_n = 1'b1;
    m_pc  = '0;
    m_ret = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // One full fetch + issue + retire, with the given ack and ready delays.
  task automatic run_instr(input int ack_dly, input int rdy_dly, input logic c, input logic z);
    logic [PC_W+3:0] instr;
    logic [PC_W-1:0] nxt;
    int waited;
    waited = 0;
    while (bus.imem_req !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk("req_seen", 32'(bus.imem_req), 32'h1);
    if (bus.imem_req !== 1'b1) return;
    chk("imem_addr", 32'(bus.imem_addr), 32'(m_pc));
    instr = mem[m_pc];
    for (int i = 0; i < ack_dly; i++) begin
      @(negedge clk);
      chk("req_hold", 32'(bus.imem_req), 32'h1);
      chk("addr_hold", 32'(bus.imem_addr), 32'(m_pc));
    end
    bus.imem_ack = 1'b1;
    bus.imem_rdata = instr;
    @(negedge clk);
    bus.imem_ack = 1'b0;
    bus.imem_rdata = 12'($urandom);
    chk("req_drop", 32'(bus.imem_req), 32'h0);
    chk("opcode", 32'(bus.opcode), 32'(instr[PC_W+3:PC_W]));
    chk("operand", 32'(bus.operand), 32'(instr[PC_W-1:0]));
    if (instr[PC_W+3:PC_W] == 4'b0111) begin
      chk("illegal_set", 32'(illegal), 32'h1);
      chk("illegal_novalid", 32'(bus.instr_valid), 32'h0);
      return;
    end
    chk("valid_up", 32'(bus.instr_valid), 32'h1);
    for (int i = 0; i < rdy_dly; i++) begin
      // Flag noise while waiting must not matter.
      bus.carry = 1'($urandom);
      bus.zero  = 1'($urandom);
      @(negedge clk);
      chk("valid_hold", 32'(bus.instr_valid), 32'h1);
      chk("opcode_hold", 32'(bus.opcode), 32'(instr[PC_W+3:PC_W]));
      chk("operand_hold", 32'(bus.operand), 32'(instr[PC_W-1:0]));
      chk("pc_hold", 32'(pc), 32'(m_pc));
    end
    bus.carry = c;
    bus.zero = z;
    bus.instr_ready = 1'b1;
    nxt = model_next_pc(m_pc, instr, c, z);
    exp_q.push_back(nxt);
    @(negedge clk);
    bus.instr_ready = 1'b0;
    bus.carry = 1'($urandom);
    bus.zero = 1'($urandom);
    m_pc = exp_q.pop_front();
    if (m_ret < (1 << RET_W) - 1) m_ret++;
    chk("pc_next", 32'(pc), 32'(m_pc));
    chk("retired", 32'(retired), 32'(m_ret));
    chk("valid_drop", 32'(bus.instr_valid), 32'h0);
    chk("refetch_req", 32'(bus.imem_req), 32'h1);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int op;
    for (int a = 0; a < (1 << PC_W); a++) begin
      op = int'($urandom_range(0, 14));
      if (op >= 7) op++;
      mem[a] = {4'(op), 8'($urandom)};
    end
    mem[8'h00] = 12'h105;
    mem[8'h01] = 12'h040;
    mem[8'h40] = 12'hA20;
    mem[8'h41] = 12'hA20;
    mem[8'h20] = 12'hB30;
    mem[8'h30] = 12'hB55;
    mem[8'h31] = 12'h231;
    mem[8'h32] = 12'hA32;

    do_reset();
    @(negedge clk);
    chk("idle_no_req", 32'(bus.imem_req), 32'h0);
    bus.instr_ready = 1'b1;              // ready outside ISSUE is ignored
    bus.imem_ack = 1'b1;                 // ack outside FETCH is ignored
    @(negedge clk);
    bus.instr_ready = 1'b0;
    bus.imem_ack = 1'b0;
    chk("idle_pc_kept", 32'(pc), 32'h0);
    pulse_start();
    chk("first_fetch_req", 32'(bus.imem_req), 32'h1);

    run_instr(0, 0, 1'b0, 1'b0);         // ADC 5 -> pc 1
    run_instr(0, 0, 1'b0, 1'b0);         // JMP 0x40
    run_instr(0, 0, 1'b1, 1'b0);         // BCC carry=1 -> 0x41
    run_instr(0, 0, 1'b0, 1'b0);         // BCC carry=0 -> 0x20
    run_instr(0, 0, 1'b0, 1'b0);         // BNE zero=0 -> 0x30
    run_instr(1, 1, 1'b0, 1'b1);         // BNE zero=1 -> 0x31
    run_instr(3, 4, 1'b0, 1'b0);         // stalled plain op -> 0x32
    run_instr(0, 0, 1'b0, 1'b0);         // BCC self-loop -> 0x32
    run_instr(0, 2, 1'b1, 1'b0);         // leave loop -> 0x33

    for (int n = 0; n < 40; n++) begin
      run_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                1'($urandom), 1'($urandom));
    end

    // pc wrap: JMP to 0xFF, plain op there wraps to 0.
    do_reset();
    mem[8'h00] = 12'h0FF;
    mem[8'hFF] = 12'h100;
    pulse_start();
    run_instr(0, 0, 1'b0, 1'b0);
    run_instr(0, 0, 1'b0, 1'b0);
    chk("wrap_pc", 32'(pc), 32'h0);

    // Illegal opcode halts; start is then ignored.
    mem[8'h00] = 12'h700;
    run_instr(0, 0, 1'b0, 1'b0);
    pulse_start();
    repeat (2) begin
      @(negedge clk);
      chk("halt_req", 32'(bus.imem_req), 32'h0);
      chk("halt_valid", 32'(bus.instr_valid), 32'h0);
      chk("halt_illegal", 32'(illegal), 32'h1);
      chk("halt_pc", 32'(pc), 32'(m_pc));
    end
    chk("halt_state", 32'(state_dbg), 32'h3);
    do_reset();

    // Reset mid-FETCH drops imem_req before the next clock edge.
    mem[8'h00] = 12'h105;
    pulse_start();
    chk("midfetch_req", 32'(bus.imem_req), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("async_req_drop", 32'(bus.imem_req), 32'h0);
    do_reset();

    // Reset mid-ISSUE drops instr_valid immediately, pc stays at reset value.
    pulse_start();
    bus.imem_ack = 1'b1;
    bus.imem_rdata = mem[8'h00];
    @(negedge clk);
    bus.imem_ack = 1'b0;
    chk("midissue_valid", 32'(bus.instr_valid), 32'h1);
    bus.instr_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("async_valid_drop", 32'(bus.instr_valid), 32'h0);
    @(negedge clk);
    chk("midissue_pc", 32'(pc), 32'h0);
    chk("midissue_retired", 32'(retired), 32'h0);
    bus.instr_ready = 1'b0;
    rst_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
endmodule
